// File: rtl/slicel_cfg_pkg.sv
// Shared definitions for the slicel configuration loader: FSM state encoding,
// config-bus size derivations and field offsets inside the flat config word.
package slicel_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        APPLY = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_e;

    // Bits of config per LUT: two truth tables of 2**base entries plus a mode bit.
    function automatic int cfg_size(input int s_xx_base);
        return 2 * (2 ** s_xx_base) + 1;
    endfunction

    function automatic int mux_lvls(input int num_luts);
        return $clog2(num_luts);
    endfunction

    function automatic int cfg_bits(input int s_xx_base, input int num_luts);
        return num_luts * cfg_size(s_xx_base) + mux_lvls(num_luts) + 1 + 2 * num_luts;
    endfunction

    function automatic int num_words(input int s_xx_base, input int num_luts, input int word_w);
        return (cfg_bits(s_xx_base, num_luts) + word_w - 1) / word_w;
    endfunction

    // Field offsets inside active[CFG_BITS-1:0]; LUT config starts at bit 0.
    function automatic int off_mux(input int s_xx_base, input int num_luts);
        return num_luts * cfg_size(s_xx_base);
    endfunction

    function automatic int off_cc(input int s_xx_base, input int num_luts);
        return off_mux(s_xx_base, num_luts) + mux_lvls(num_luts);
    endfunction

    function automatic int off_regs(input int s_xx_base, input int num_luts);
        return off_cc(s_xx_base, num_luts) + 1;
    endfunction

endpackage

// File: rtl/slicel_cfg_loader.sv
// Word-serial config loader for one slicel: collects a framed stream into a
// shadow register, verifies the XOR check word, then commits the frame to the
// active config bus and pulses cen for APPLY_CYCLES cycles.
module slicel_cfg_loader
    import slicel_cfg_pkg::*;
#(
    parameter int S_XX_BASE    = 4,
    parameter int NUM_LUTS     = 4,
    parameter int WORD_W       = 8,
    parameter int APPLY_CYCLES = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [WORD_W-1:0]                           in_data,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    output logic                                        cen,
    output logic [NUM_LUTS*cfg_size(S_XX_BASE)-1:0]     luts_config_in,
    output logic [mux_lvls(NUM_LUTS)-1:0]               inter_lut_mux_config,
    output logic                                        config_use_cc,
    output logic [2*NUM_LUTS-1:0]                       regs_config_in,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        err
);

    localparam int CFG_SIZE  = cfg_size(S_XX_BASE);
    localparam int MUX_LVLS  = mux_lvls(NUM_LUTS);
    localparam int CFG_BITS  = cfg_bits(S_XX_BASE, NUM_LUTS);
    localparam int NUM_WORDS = num_words(S_XX_BASE, NUM_LUTS, WORD_W);
    localparam int SHADOW_W  = NUM_WORDS * WORD_W;
    localparam int OFF_MUX   = off_mux(S_XX_BASE, NUM_LUTS);
    localparam int OFF_CC    = off_cc(S_XX_BASE, NUM_LUTS);
    localparam int OFF_REGS  = off_regs(S_XX_BASE, NUM_LUTS);
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);
    localparam int APC_W     = $clog2(APPLY_CYCLES + 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [APC_W-1:0]     apply_cnt_q, apply_cnt_d;
    logic [WORD_W-1:0]    xor_q, xor_d;
    logic [SHADOW_W-1:0]  shadow_q, shadow_d;
    logic [CFG_BITS-1:0]  active_q, active_d;
    logic                 xfer;

    // Status and handshake come from registered state only, never from inputs.
    assign in_ready = (state_q == LOAD) || (state_q == CHECK);
    assign busy     = (state_q == LOAD) || (state_q == CHECK) || (state_q == APPLY);
    assign cen      = (state_q == APPLY);
    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);
    assign xfer     = in_valid && in_ready;

    // The slice only ever sees the committed config, never the shadow.
    assign luts_config_in       = active_q[0 +: NUM_LUTS*CFG_SIZE];
    assign inter_lut_mux_config = active_q[OFF_MUX +: MUX_LVLS];
    assign config_use_cc        = active_q[OFF_CC];
    assign regs_config_in       = active_q[OFF_REGS +: 2*NUM_LUTS];

    // Next-state and datapath updates; start outside APPLY always (re)opens a frame.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        apply_cnt_d = apply_cnt_q;
        xor_d       = xor_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                    xor_d   = '0;
                end
            end
            LOAD: begin
                if (start) begin
                    count_d = '0;
                    xor_d   = '0;
                end else if (xfer) begin
                    shadow_d = {in_data, shadow_q[SHADOW_W-1:WORD_W]};
                    count_d  = count_q + 1'b1;
                    xor_d    = xor_q ^ in_data;
                    if (count_q == CNT_W'(NUM_WORDS - 1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                    xor_d   = '0;
                end else if (xfer) begin
                    if (in_data == xor_q) begin
                        active_d    = shadow_q[CFG_BITS-1:0];
                        apply_cnt_d = '0;
                        state_d     = APPLY;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            APPLY: begin
                if (apply_cnt_q == APC_W'(APPLY_CYCLES - 1)) begin
                    state_d = DONE;
                end else begin
                    apply_cnt_d = apply_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; async reset drops cen immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            apply_cnt_q <= '0;
            xor_q       <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            apply_cnt_q <= apply_cnt_d;
            xor_q       <= xor_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

endmodule

// File: tb/tb_slicel_cfg_loader.sv
// Directed plus randomized bench for slicel_cfg_loader. Expected config is
// rebuilt from the words sent (word k lands at bits [k*8 +: 8]) and the check
// word is the XOR of all data words.
module tb_slicel_cfg_loader;
    import slicel_cfg_pkg::*;

    localparam int BASE      = 4;
    localparam int NL        = 4;
    localparam int WW        = 8;
    localparam int APC       = 2;
    localparam int CFG_SIZE  = cfg_size(BASE);
    localparam int MUX_LVLS  = mux_lvls(NL);
    localparam int CFG_BITS  = cfg_bits(BASE, NL);
    localparam int NUM_WORDS = num_words(BASE, NL, WW);
    localparam int OFF_MUX   = off_mux(BASE, NL);
    localparam int OFF_CC    = off_cc(BASE, NL);
    localparam int OFF_REGS  = off_regs(BASE, NL);

    logic                        clk;
    logic                        rst;
    logic                        start;
    logic [WW-1:0]               in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        cen;
    logic [NL*CFG_SIZE-1:0]      luts_config_in;
    logic [MUX_LVLS-1:0]         inter_lut_mux_config;
    logic                        config_use_cc;
    logic [2*NL-1:0]             regs_config_in;
    logic                        busy;
    logic                        done;
    logic                        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WW-1:0]       fw [NUM_WORDS];
    logic [CFG_BITS-1:0] exp_cfg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    slicel_cfg_loader #(
        .S_XX_BASE(BASE), .NUM_LUTS(NL), .WORD_W(WW), .APPLY_CYCLES(APC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cen(cen), .luts_config_in(luts_config_in),
        .inter_lut_mux_config(inter_lut_mux_config), .config_use_cc(config_use_cc),
        .regs_config_in(regs_config_in), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [WW-1:0] frame_xor();
        logic [WW-1:0] x = '0;
        for (int k = 0; k < NUM_WORDS; k++) x ^= fw[k];
        return x;
    endfunction

    function automatic logic [CFG_BITS-1:0] model_cfg();
        logic [NUM_WORDS*WW-1:0] v = '0;
        for (int k = 0; k < NUM_WORDS; k++) v[k*WW +: WW] = fw[k];
        return v[CFG_BITS-1:0];
    endfunction

    task automatic check_cfg(input string tag);
        chk({tag, "_luts"}, luts_config_in, exp_cfg[0 +: NL*CFG_SIZE]);
        chk({tag, "_mux"},  inter_lut_mux_config, exp_cfg[OFF_MUX +: MUX_LVLS]);
        chk({tag, "_cc"},   config_use_cc, exp_cfg[OFF_CC]);
        chk({tag, "_regs"}, regs_config_in, exp_cfg[OFF_REGS +: 2*NL]);
    endtask

    // Called at a negedge; returns at the negedge just after the word's transfer edge.
    task automatic send_word(input logic [WW-1:0] w, input int maxgap);
        int g;
        int waited;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", waited < 20, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [WW-1:0] chkw, input int maxgap);
        for (int k = 0; k < NUM_WORDS; k++) send_word(fw[k], maxgap);
        send_word(chkw, maxgap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // cen high for APC cycles starting the cycle after the check word, then done.
    task automatic check_apply(input string tag, input bit start_in_apply);
        for (int k = 0; k <= APC; k++) begin
            chk({tag, "_cen"},  cen,  k < APC);
            chk({tag, "_busy"}, busy, k < APC);
            chk({tag, "_done"}, done, k == APC);
            start = start_in_apply && (k == 0);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_err"}, err, 1'b0);
        check_cfg(tag);
    endtask

    task automatic check_error(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_cen"},  cen,  1'b0);
            chk({tag, "_err"},  err,  1'b1);
            chk({tag, "_done"}, done, 1'b0);
            @(negedge clk);
        end
        check_cfg(tag);
    endtask

    initial begin
        logic [WW-1:0] c;
        bit bad;

        // Reset behaviour
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        exp_cfg = '0;
        repeat (3) @(negedge clk);
        chk("rst_cen", cen, 1'b0);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_state", dut.state_q, IDLE);
        check_cfg("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", in_ready, 1'b0);
        pulse_start();
        chk("start_ready", in_ready, 1'b1);
        chk("start_busy", busy, 1'b1);

        // Good frame 0x01..0x12
        for (int k = 0; k < NUM_WORDS; k++) fw[k] = WW'(k + 1);
        send_frame(frame_xor(), 0);
        exp_cfg = model_cfg();
        check_apply("good", 1'b0);
        chk("good_lut0", luts_config_in[7:0], 8'h01);
        chk("good_lut1", luts_config_in[15:8], 8'h02);

        // Bad check word: config keeps previous frame
        pulse_start();
        chk("bad_startclr_done", done, 1'b0);
        send_frame(8'h00, 0);
        check_error("bad");

        // Same frame with random valid gaps
        pulse_start();
        send_frame(frame_xor(), 5);
        check_apply("stall", 1'b0);

        // Random frames, some corrupted, one with start ignored during APPLY
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < NUM_WORDS; k++) fw[k] = WW'($urandom);
            pulse_start();
            bad = ($urandom_range(3, 0) == 0);
            c = frame_xor() ^ (bad ? WW'(1 << $urandom_range(WW - 1, 0)) : WW'(0));
            send_frame(c, 2);
            if (!bad) begin
                exp_cfg = model_cfg();
                check_apply("rand", it == 1);
            end else begin
                check_error("rand_bad");
            end
        end

        // Restart mid-frame; transfer during the restart edge is dropped
        pulse_start();
        for (int k = 0; k < 5; k++) send_word(WW'($urandom), 0);
        start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < NUM_WORDS; k++) fw[k] = WW'($urandom);
        fw[0] = 8'hA5;
        send_frame(frame_xor(), 0);
        exp_cfg = model_cfg();
        check_apply("restart", 1'b0);
        chk("restart_lut0", luts_config_in[7:0], 8'hA5);

        // Async reset during first APPLY cycle
        for (int k = 0; k < NUM_WORDS; k++) fw[k] = WW'($urandom);
        pulse_start();
        send_frame(frame_xor(), 0);
        chk("arst_pre_cen", cen, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("arst_cen", cen, 1'b0);
        chk("arst_ready", in_ready, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_state", dut.state_q, IDLE);
        exp_cfg = '0;
        check_cfg("arst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
